// File: rtl/lstm_wi_fetch_seq.sv
// Streams the LSTM input-weight ROM to the gate MAC array, DEPTH rows per timestep,
// through one registered output stage with valid/ready backpressure.
module lstm_wi_fetch_seq #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int DEPTH     = 156,
    parameter int ADDR_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  num_steps,
    input  logic                        abort,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [UNITS_NUM*D_WL-1:0]   rom_data,
    output logic [UNITS_NUM*D_WL-1:0]   w_data,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic [ADDR_W-1:0]           w_addr,
    output logic                        w_first,
    output logic                        w_last,
    output logic [7:0]                  w_step,
    output logic                        busy,
    output logic                        done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state;
    logic [7:0] n_steps;
    logic [7:0] step;
    logic       ld;

    assign ld   = (state == RUN) && (!w_valid || w_ready);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_steps  <= '0;
            step     <= '0;
            rom_addr <= '0;
            w_data   <= '0;
            w_valid  <= 1'b0;
            w_addr   <= '0;
            w_first  <= 1'b0;
            w_last   <= 1'b0;
            w_step   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rom_addr <= '0;
                    w_valid  <= 1'b0;
                    if (start) begin
                        if (num_steps != 8'd0) begin
                            n_steps <= num_steps;
                            step    <= '0;
                            state   <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        w_valid  <= 1'b0;
                        rom_addr <= '0;
                    end else if (ld) begin
                        w_data  <= rom_data;
                        w_addr  <= rom_addr;
                        w_first <= (rom_addr == '0);
                        w_last  <= (rom_addr == LAST_ADDR);
                        w_step  <= step;
                        w_valid <= 1'b1;
                        if (rom_addr < LAST_ADDR) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end else begin
                            // Wrap explicitly at DEPTH-1; final step hands the last beat to DRAIN.
                            rom_addr <= '0;
                            if (step == n_steps - 8'd1)
                                state <= DRAIN;
                            else
                                step <= step + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state    <= IDLE;
                        w_valid  <= 1'b0;
                        rom_addr <= '0;
                    end else if (w_ready) begin
                        w_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_wi_fetch_seq.sv
// Randomized bench for lstm_wi_fetch_seq: expected beats come from a per-step/per-row
// queue and event timing from beat and stall counts.
module tb_lstm_wi_fetch_seq;

    localparam int D_WL      = 24;
    localparam int UNITS_NUM = 5;
    localparam int DEPTH     = 156;
    localparam int ADDR_W    = 8;
    localparam int W         = UNITS_NUM * D_WL;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        num_steps = '0;
    logic              abort = 1'b0;
    logic              w_ready = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [W-1:0]      rom_data;
    logic [W-1:0]      w_data;
    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic              w_first;
    logic              w_last;
    logic [7:0]        w_step;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    lstm_wi_fetch_seq #(
        .D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .w_addr(w_addr), .w_first(w_first), .w_last(w_last),
        .w_step(w_step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_row(input int a);
        logic [W-1:0] r;
        r = '0;
        for (int u = 0; u < UNITS_NUM; u++) r[u*D_WL +: D_WL] = D_WL'(a);
        return r;
    endfunction

    always_comb rom_data = rom_row(int'(rom_addr));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_addr"}, W'(rom_addr), '0);
        check({tag, "_w_data"},   w_data,       '0);
        check({tag, "_w_valid"},  W'(w_valid),  '0);
        check({tag, "_w_addr"},   W'(w_addr),   '0);
        check({tag, "_w_first"},  W'(w_first),  '0);
        check({tag, "_w_last"},   W'(w_last),   '0);
        check({tag, "_w_step"},   W'(w_step),   '0);
        check({tag, "_busy"},     W'(busy),     '0);
        check({tag, "_done"},     W'(done),     '0);
    endtask

    // One start..done transaction; negative beat indices disable the corresponding event.
    task automatic run_stream(input int n, input int ready_pct, input int mid_start_beat,
                              input int abort_beat, input int rst_beat);
        int           exp_addr[$];
        int           exp_step[$];
        int           cyc, stalls, beats, last_hs, ea, es;
        bit           done_seen, prev_stall;
        logic [W-1:0] held_data;
        logic [ADDR_W-1:0] held_addr;

        for (int s = 0; s < n; s++)
            for (int a = 0; a < DEPTH; a++) begin
                exp_addr.push_back(a);
                exp_step.push_back(s);
            end

        @(negedge clk);
        start     = 1'b1;
        num_steps = 8'(n);
        w_ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_c1",     W'(busy),     W'(n != 0));
        check("rom_addr_c1", W'(rom_addr), '0);
        check("valid_c1",    W'(w_valid),  '0);
        if (n == 0) begin
            check("done_zero_steps", W'(done), W'(1));
            @(negedge clk);
            check("done_zero_pulse", W'(done),    '0);
            check("busy_zero_steps", W'(busy),    '0);
            check("valid_zero_steps", W'(w_valid), '0);
            return;
        end

        stalls = 0; beats = 0; last_hs = -1;
        done_seen = 1'b0; prev_stall = 1'b0;
        held_data = '0; held_addr = '0;
        while (!done_seen && cyc < 4000) begin
            start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                check("done_cycle",      W'(cyc),     W'(2 + DEPTH * n + stalls));
                check("done_after_hs",   W'(cyc),     W'(last_hs + 1));
                check("beats_total",     W'(beats),   W'(DEPTH * n));
                check("done_not_valid",  W'(w_valid), '0);
                check("busy_at_done",    W'(busy),    '0);
            end else begin
                if (!busy) check("busy_run", W'(busy), W'(1));
                if (prev_stall) begin
                    check("stall_data", w_data,      held_data);
                    check("stall_addr", W'(w_addr),  W'(held_addr));
                end
                if (w_valid && beats == 0 && ready_pct == 100)
                    check("first_beat_cycle", W'(cyc), W'(2));
                w_ready = ($urandom_range(99) < ready_pct);

                if (w_valid && beats == abort_beat) begin
                    w_ready = 1'b0;
                    abort   = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_valid",    W'(w_valid),  '0);
                    check("abort_busy",     W'(busy),     '0);
                    check("abort_rom_addr", W'(rom_addr), '0);
                    check("abort_done",     W'(done),     '0);
                    @(negedge clk);
                    check("abort_no_done",  W'(done),     '0);
                    return;
                end
                if (w_valid && beats == rst_beat) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    check_reset_values("async_rst");
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (w_valid && beats == mid_start_beat && !prev_stall) begin
                    start     = 1'b1;
                    num_steps = 8'(n + 3);
                end

                if (w_valid && w_ready) begin
                    if (exp_addr.size() == 0) begin
                        check("extra_beat", W'(1), '0);
                    end else begin
                        ea = exp_addr.pop_front();
                        es = exp_step.pop_front();
                        check("w_addr",  W'(w_addr),  W'(ea));
                        check("w_step",  W'(w_step),  W'(es));
                        check("w_first", W'(w_first), W'(ea == 0));
                        check("w_last",  W'(w_last),  W'(ea == DEPTH - 1));
                        check("w_data",  w_data,      rom_row(ea));
                    end
                    beats++;
                    last_hs = cyc;
                end
                prev_stall = w_valid && !w_ready;
                if (prev_stall) stalls++;
                held_data = w_data;
                held_addr = w_addr;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done_seen) check("done_timeout", '0, W'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        run_stream(1, 100, -1, -1, -1);
        run_stream(3, 100, -1, -1, -1);
        run_stream(2, 50,  -1, -1, -1);
        run_stream(0, 100, -1, -1, -1);
        run_stream(2, 100, 40, -1, -1);
        run_stream(2, 100, -1, 100, -1);
        run_stream(1, 100, -1, -1, -1);
        run_stream(2, 70,  -1, -1, 77);
        check_reset_values("post_rst");
        run_stream(1, 100, -1, -1, -1);
        run_stream(4, 30,  -1, -1, -1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lstm_wi_fetch_seq.md
# lstm_wi_fetch_seq

Sequencer that streams the LSTM input-weight matrix out of the combinational weight ROM (`wi_buffer`, 156 rows of UNITS_NUM×D_WL bits) to the gate MAC array. On `start` it sweeps the ROM address from 0 to DEPTH-1 once per timestep, for `num_steps` timesteps. Each row is registered into an output stage with valid/ready backpressure and tagged with address, first/last and step information. It sits between the layer control FSM (start/done) and the MAC array (stream consumer).

## Interface
- D_WL, 24, weight word width
- UNITS_NUM, 5, words per ROM row
- DEPTH, 156, ROM rows swept per timestep
- ADDR_W, 8, ROM address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- num_steps  in  8  timesteps to stream; latched when start is accepted
- abort  in  1  synchronous cancel of a running sweep
- rom_addr  out  ADDR_W  ROM address (registered counter)
- rom_data  in  UNITS_NUM*D_WL  ROM row, combinational from rom_addr
- w_data  out  UNITS_NUM*D_WL  registered weight row
- w_valid  out  1  w_data valid
- w_ready  in  1  consumer accepts beat when w_valid&&w_ready
- w_addr  out  ADDR_W  row index of current beat
- w_first  out  1  beat is row 0
- w_last  out  1  beat is row DEPTH-1
- w_step  out  8  timestep index of current beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: rom_addr=0, w_valid=0. On start with num_steps!=0, latch num_steps, step counter=0, rom_addr=0, go to RUN. On start with num_steps==0, pulse done next cycle, stay IDLE, emit no beats.
- Load condition ld = (state==RUN) && (!w_valid || w_ready).
- On ld:
  - w_data<=rom_data, w_addr<=rom_addr, w_first<=(rom_addr==0), w_last<=(rom_addr==DEPTH-1), w_step<=step, w_valid<=1.
  - If rom_addr<DEPTH-1, rom_addr increments.
  - Otherwise rom_addr wraps to 0 and step increments. If step==num_steps-1, go to DRAIN instead.
- RUN with w_valid && !w_ready: every output and rom_addr holds stable. No beat is dropped or duplicated.
- DRAIN: when w_ready, set w_valid<=0, done<=1 for one cycle, go to IDLE. Otherwise hold.
- abort in RUN or DRAIN: next cycle IDLE, w_valid=0, rom_addr=0, no done pulse. A pending beat is discarded. abort in IDLE has no effect.
- start while busy is ignored; num_steps is not re-latched.
- Address arithmetic is ADDR_W bits, with explicit wrap at DEPTH-1, not at 2^ADDR_W. Step arithmetic is 8 bits, so the maximum is 255 steps.
- Reset values: state IDLE, rom_addr 0, w_data 0, w_valid 0, w_addr 0, w_first 0, w_last 0, w_step 0, busy 0, done 0.
- Reset mid-sweep returns immediately to these values.

## Timing
- start high in cycle 0 → busy and RUN in cycle 1 (rom_addr=0) → first beat w_valid=1 in cycle 2 (w_addr=0, w_first=1).
- With w_ready held high: one beat per cycle. The last beat (w_last=1, w_step=N-1) appears in cycle 1+DEPTH·N. done is high in cycle 2+DEPTH·N, and busy falls in the same cycle.
- Each ready-low cycle adds exactly one cycle to all later events.
- rom_addr leads w_addr by one row while streaming. The ROM path is combinational, and rom_data → w_data is a single register stage.
- done is never asserted together with w_valid.

## Test plan
- Bench ROM returns row = {UNITS_NUM{addr zero-extended to D_WL}}. Drive start with num_steps=1 and w_ready=1 → 156 beats in cycles 2..157, w_addr 0..155, w_data matching the pattern, w_first only at addr 0, w_last only at addr 155, done in cycle 158.
- num_steps=3 with w_ready=1 → 468 contiguous beats. w_step goes 0,1,2, and w_addr wraps 155→0 with no bubble. done in cycle 470.
- num_steps=2 with random w_ready (50%) → beat sequence identical to the ready-high run. w_data stays stable while stalled. done comes exactly one cycle after the final handshake.
- num_steps=0 → no w_valid, done pulse in cycle 1, busy stays 0. A second start asserted mid-sweep (at beat 40) is ignored and the beat count is unchanged.
- abort at beat 100 with w_valid=1 and w_ready=0 → next cycle w_valid=0, busy=0, rom_addr=0, no done. A new start then restarts at w_addr=0, w_step=0.
- Async rst asserted at beat 77 mid-cycle → all outputs go to reset values without waiting for a clock edge. After release, start with num_steps=1 completes normally.
